// File: rtl/keypad_pkg.sv
// Shared constants, column state type and helpers for the 4x4 keypad front end.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = 16;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } kp_col_t;

  function automatic logic [3:0] kp_index(input logic [1:0] col, input logic [1:0] row);
    return {col, row};
  endfunction

  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'd1)) == 16'h0000);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-matrix debouncer: counts identical sweeps and commits single-key
// snapshots (or "no key") to the registered one-hot code.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic               sweep_end,
  input  logic [KP_KEYS-1:0] cur,
  output logic [KP_KEYS-1:0] onehot,
  output logic               press
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [KP_KEYS-1:0] last;
  logic [CW-1:0]      stable_cnt;
  logic [CW-1:0]      cnt_next;
  logic               commit;

  // Commit only on the sweep that first reaches the threshold, so a held key
  // with a saturated counter never re-commits.
  always_comb begin
    cnt_next = CW'(1);
    if (cur == last) begin
      cnt_next = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CW'(1);
    end
    commit = sweep_end && (cnt_next == CNT_MAX) &&
             ((stable_cnt != CNT_MAX) || (cur != last));
  end

  always_ff @(posedge clk) begin
    if (RSTn) begin
      last       <= '0;
      stable_cnt <= '0;
      onehot     <= '0;
      press      <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sweep_end) begin
        last       <= cur;
        stable_cnt <= cnt_next;
      end
      // Multi-key snapshots (ghosting) leave the previous code in place.
      if (commit) begin
        if (cur == '0) begin
          onehot <= '0;
        end else if (is_onehot16(cur)) begin
          onehot <= cur;
          press  <= (cur != onehot);
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: drives one column low at a time, snapshots
// the rows at the end of each column slot and hands full sweeps to the debouncer.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic               clk,
  input  logic               RSTn,
  input  logic [KP_ROWS-1:0] row_in,
  output logic [KP_COLS-1:0] col_out,
  output logic [KP_KEYS-1:0] onehot,
  output logic               press
);

  localparam int SW = $clog2(SCAN_DIV);

  kp_col_t            col;
  logic [SW-1:0]      slot;
  logic [11:0]        snap;
  logic               sample;
  logic               sweep_end;
  logic [KP_KEYS-1:0] cur;

  // Sampling on the last slot cycle gives the rows the rest of the slot to settle.
  assign sample    = (slot == SW'(SCAN_DIV - 1));
  assign sweep_end = sample && (col == COL3);
  assign cur       = {~row_in, snap};
  assign col_out   = ~(4'b0001 << col);

  always_ff @(posedge clk) begin
    if (RSTn) begin
      col  <= COL0;
      slot <= '0;
      snap <= '0;
    end else if (sample) begin
      slot <= '0;
      col  <= kp_col_t'(col + 2'd1);
      if (col != COL3) begin
        snap[kp_index(col, 2'd0) +: KP_ROWS] <= ~row_in;
      end
    end else begin
      slot <= slot + SW'(1);
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .RSTn     (RSTn),
    .sweep_end(sweep_end),
    .cur      (cur),
    .onehot   (onehot),
    .press    (press)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a keypad matrix model and an output-event
// scoreboard; SCAN_DIV=4, DEBOUNCE_SCANS=3 gives a 16-cycle sweep.
module tb_keypad_scan;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int SWEEP          = 4 * SCAN_DIV;

  logic        clk  = 1'b0;
  logic        RSTn = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] onehot;
  logic        press;
  logic [15:0] keys = 16'h0000;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [16:0] sb[$];
  logic        mon_en      = 1'b0;
  logic [15:0] prev_onehot = 16'h0000;

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) dut (
    .clk    (clk),
    .RSTn   (RSTn),
    .row_in (row_in),
    .col_out(col_out),
    .onehot (onehot),
    .press  (press)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && (col_out[c] == 1'b0)) row_in[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k);
    keys = k;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    RSTn = 1'b1;
    @(posedge clk);
    #1;
    RSTn = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    checkOutput(tag, sb.size(), 0);
  endtask

  // Any change of onehot, or any press pulse, must match the next queued event.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((onehot !== prev_onehot) || (press !== 1'b0)) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_event", {15'b0, onehot, press}, {15'b0, prev_onehot, 1'b0});
        end else begin
          checkOutput("event", {15'b0, onehot, press}, {15'b0, sb.pop_front()});
        end
      end
      prev_onehot = onehot;
    end
  end

  initial begin
    // Reset and idle scan
    applyStimulus(16'h0000);
    resetPulse();
    checkOutput("reset_onehot", onehot, 16'h0000);
    checkOutput("reset_press", press, 1'b0);
    mon_en = 1'b1;
    for (int t = 0; t < 200; t++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((t / SCAN_DIV) % 4));
      checkOutput("idle_col", col_out, exp_col);
      checkOutput("idle_onehot", onehot, 16'h0000);
      checkOutput("idle_press", press, 1'b0);
      @(posedge clk);
      #1;
    end

    // Single press (col2,row1), held from the start of a sweep
    applyStimulus(16'h0200);
    sb.push_back({16'h0200, 1'b1});
    resetPulse();
    repeat (3 * SWEEP - 1) @(posedge clk);
    #1;
    checkOutput("press_before_commit", onehot, 16'h0000);
    @(posedge clk);
    #1;
    checkOutput("press_commit_onehot", onehot, 16'h0200);
    checkOutput("press_commit_strobe", press, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("press_strobe_one_cycle", press, 1'b0);
    repeat (10 * SWEEP) @(posedge clk);
    #1;
    checkOutput("held_onehot", onehot, 16'h0200);
    checkOutput("held_no_repeat", sb.size(), 0);

    // Release
    applyStimulus(16'h0000);
    sb.push_back({16'h0000, 1'b0});
    waitDrain(5 * SWEEP, "release_commit");
    #1;
    checkOutput("release_onehot", onehot, 16'h0000);

    // Bounce on (col0,row3), then hold
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i % 2 == 0) ? 16'h0008 : 16'h0000);
      repeat (5) @(posedge clk);
    end
    #1;
    checkOutput("bounce_no_commit", onehot, 16'h0000);
    applyStimulus(16'h0008);
    sb.push_back({16'h0008, 1'b1});
    waitDrain(6 * SWEEP, "bounce_commit");
    #1;
    checkOutput("bounce_onehot", onehot, 16'h0008);

    // Multi-key holds the old code, then the survivor commits
    applyStimulus(16'h1008);
    repeat (5 * SWEEP) @(posedge clk);
    #1;
    checkOutput("multi_hold", onehot, 16'h0008);
    checkOutput("multi_no_event", sb.size(), 0);
    applyStimulus(16'h1000);
    sb.push_back({16'h1000, 1'b1});
    waitDrain(6 * SWEEP, "multi_commit");
    #1;
    checkOutput("multi_onehot", onehot, 16'h1000);

    // Reset during COL2 with the key still held
    begin
      int n = 0;
      while (col_out !== 4'b1011 && n < 2 * SWEEP) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    checkOutput("reach_col2", col_out, 4'b1011);
    sb.push_back({16'h0000, 1'b0});
    sb.push_back({16'h1000, 1'b1});
    RSTn = 1'b1;
    @(posedge clk);
    #1;
    RSTn = 1'b0;
    checkOutput("midreset_col", col_out, 4'b1110);
    checkOutput("midreset_onehot", onehot, 16'h0000);
    checkOutput("midreset_press", press, 1'b0);
    waitDrain(6 * SWEEP, "midreset_recommit");
    #1;
    checkOutput("midreset_onehot_after", onehot, 16'h1000);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad front end for the lock/timer display path. Scans a 4×4 active-low key matrix column by column and debounces whole-matrix snapshots. Delivers the 16-bit one-hot key code consumed by `onehot2binary`: the code is held for as long as one key is stably pressed, and is zero when no key is pressed. It also provides a one-cycle press strobe for diagnostics and LED feedback.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clock cycles each column is driven (1 ms at 50 MHz). Must be ≥ 2.
- `DEBOUNCE_SCANS`, 20: number of consecutive identical full sweeps required to commit a snapshot. Must be ≥ 1.

Ports:
- `clk`, input, 1: the single system clock.
- `RSTn`, input, 1: synchronous, active-high reset. Despite the codebase name, asserting it high resets the block.
- `row_in`, input, 4: keypad rows, active-low, externally pulled up, already synchronised upstream.
- `col_out`, output, 4: column drive, active-low. Exactly one bit is low at all times.
- `onehot`, output, 16: debounced key code. Bit index is `col*4 + row`. All zeros means no key.
- `press`, output, 1: one-cycle pulse on each commit where `onehot` changes to a different nonzero value.

## Operation
- **Column FSM.** States are COL0 → COL1 → COL2 → COL3 → COL0, each lasting `SCAN_DIV` cycles.
  - `col_out` = ~(1<<col).
  - The slot counter runs 0..`SCAN_DIV`-1.
  - Rows are sampled only on slot count `SCAN_DIV`-1, which gives the settle time. Sampled bits are `~row_in` into `snap[col*4 +: 4]`.
- **Sweep end** is the sample cycle of COL3. The complete snapshot `cur` is formed from `snap` bits 0..11 plus the live `~row_in` for bits 12..15.
- **Debounce** runs at sweep end:
  - If `cur` == `last`, `stable_cnt` increments, saturating at `DEBOUNCE_SCANS`.
  - Otherwise `stable_cnt` ← 1.
  - `last` ← `cur` in both cases.
  - A commit happens when the new `stable_cnt` value equals `DEBOUNCE_SCANS`, and only on the sweep where it first reaches that value.
- **Commit rules:**
  - If `cur` is zero, `onehot` ← 0.
  - If `cur` has exactly one bit set, `onehot` ← `cur`.
  - If `cur` has two or more bits set (multi-key or ghosting), `onehot` holds its previous value.
- **Press strobe:** `press` = 1 for the single cycle after a commit that loads a nonzero `cur` different from the old `onehot`. Otherwise `press` = 0.
- **Arithmetic:**
  - Slot counter width is clog2(`SCAN_DIV`) and wraps to 0 after `SCAN_DIV`-1.
  - `stable_cnt` width is clog2(`DEBOUNCE_SCANS`+1).

## Timing
- **Reset values:** `col_out` = 4'b1110 (COL0), slot counter 0, `snap` 0, `last` 0, `stable_cnt` 0, `onehot` 16'h0000, `press` 0.
- **Sweep period** is 4·`SCAN_DIV` cycles.
- **Latency:** a key that is stable from before a sweep's COL0 sample commits at the end of sweep number `DEBOUNCE_SCANS`.
  - Worst case is (`DEBOUNCE_SCANS`+1)·4·`SCAN_DIV` cycles from the press.
  - Release uses the same rule.
- **Output update:** `onehot` and `press` are registered. They change on the clock edge that ends the commit cycle.
- **Bounce:** any snapshot change before commit restarts counting at 1. `onehot` does not glitch.
- **Held key:** a key held indefinitely keeps `stable_cnt` saturated. There is no repeat commit and no repeat `press`.
- **Reset mid-sweep:** the block returns to COL0 with slot count 0 on the next edge. A key that is still pressed re-commits after a full debounce, producing a new `press`.
- **Simultaneous release and press:** a fast change from key A to key B is just a new nonzero snapshot. It commits B directly (A→B with no zero in between) and pulses `press`.

## Structure
- Shared package `keypad_pkg`:
  - `KP_ROWS` = 4, `KP_COLS` = 4, `KP_KEYS` = 16.
  - Function `kp_index(col,row)` = col*4+row.
  - Function `is_onehot16(v)`, true when exactly one bit is set.
- One sub-module, `keypad_debounce`:
  - Inputs: `clk`, `RSTn`, `sweep_end`, `cur[15:0]`.
  - Outputs: `onehot` and `press`.
  - Holds `last`, `stable_cnt` and the commit rules.
  - The top keeps the column FSM and the slot counter.

## Test plan
Use `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=3, so a sweep is 16 cycles. The keypad model pulls `row_in[r]` low while the key at (c,r) is pressed and `col_out[c]` is low.

- **Reset / idle:** after `RSTn` pulse with no keys → `col_out` = 1110, rotating 1101, 1011, 0111 every 4 cycles; `onehot` = 0 and `press` = 0 for 200 cycles.
- **Single press:** hold key (col2,row1) → `onehot` = 16'h0200 after the 3rd complete sweep, `press` high exactly one cycle, and no second pulse while held for 10 sweeps.
- **Bounce:** toggle (col0,row3) every 5 cycles for 40 cycles, then hold → `onehot` stays 0 until 3 clean sweeps after settling, then becomes 16'h0008.
- **Release:** from 16'h0200, release the key → `onehot` = 0 after 3 sweeps, with `press` not asserted.
- **Multi-key:** with 16'h0008 committed, add (col3,row0) → `onehot` holds 16'h0008. Release the first key → commits 16'h1000 with `press` pulse.
- **Mid-operation reset:** assert `RSTn` during COL2 while a key is held → outputs return to reset values next edge. The key re-commits after 3 sweeps with a fresh `press`.
